keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Drives the column lines of the 4x4 push-button matrix and scans the row lines. It debounces presses and releases, then delivers exactly one 4-bit key code per physical press over a valid/ready handshake to the vending-machine control FSM. It also exports shift_col, so the existing keypad decoder can keep using the same column pattern.

Parameters:
SCAN_DIV, 1000, clock cycles each column is driven before rotating (min 4)
DEBOUNCE_CYC, 20000, consecutive stable cycles required to confirm a press or a release (min 2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
row  input  4  matrix row lines, active-low, asynchronous to clk, pulled up (idle 4'b1111)
shift_col  output  4  column drive, one-hot-low, rotates 1110->1101->1011->0111->1110
key_code  output  4  confirmed key code = col_index*4 + row_index (col 1110 = index 0, row 1110 = index 0)
key_valid  output  1  key_code holds a pending key event
key_ready  input  1  consumer accepts; transfer occurs on the clk edge where key_valid && key_ready
key_held  output  1  high from press confirmation until release confirmation

Behaviour:
- Reset (reset==0, async, immediate, also mid-operation): shift_col=4'b1110, key_code=0, key_valid=0, key_held=0, state=SCAN, all counters and synchroniser flops cleared (synchroniser flops to 1111).
- row passes through a 2-flop synchroniser (row_s); all decisions use row_s only.
- Scan counter width: $clog2(SCAN_DIV). Debounce counter width: $clog2(DEBOUNCE_CYC+1). Neither counter wraps silently; each is reset on every state entry.
- SCAN:
  - shift_col is held for SCAN_DIV cycles.
  - On the last cycle of the period, if row_s has exactly one zero, capture row_s into row_cap and go to DEBOUNCE; shift_col freezes.
  - Otherwise (1111, or two or more zeros, i.e. ghosting or multi-key), rotate shift_col = {shift_col[2:0],shift_col[3]} and restart the period.
- DEBOUNCE:
  - Each cycle, if row_s==row_cap, increment the counter; on reaching DEBOUNCE_CYC, go to PRESSED.
  - Any mismatch returns to SCAN. The column rotates, as for a no-press period.
- PRESSED entry (single edge): key_code<=encode(shift_col,row_cap), key_valid<=1, key_held<=1.
- PRESSED:
  - key_valid stays high and key_code stays stable until the handshake completes. This holds even if the key is released first; the event is latched and never dropped.
  - On the handshake edge, key_valid<=0, then go to RELEASE.
  - If key_ready is already high on the entry cycle, the transfer happens on the following edge (valid is high for at least one cycle).
- RELEASE:
  - shift_col stays frozen. Each cycle that row_s==1111, increment the counter; any zero clears the counter.
  - On reaching DEBOUNCE_CYC: key_held<=0, rotate shift_col, go to SCAN.
  - There is no auto-repeat; a held key produces exactly one event.
- Latency: a clean press on the active column yields key_valid 2 (sync) + remaining scan period + DEBOUNCE_CYC + 1 cycles after row changes. Worst case is 2 + 4*SCAN_DIV + DEBOUNCE_CYC + 1.
- key_ready while key_valid==0 is ignored.
- Only one event is outstanding at a time; the scanner does not resume scanning until the event is accepted and the key is released.

Decomposition:
- Package keypad_pkg:
  - state enum {SCAN, DEBOUNCE, PRESSED, RELEASE}
  - constants COL_INIT=4'b1110, ROW_IDLE=4'b1111
  - function onehot_low_idx(4-bit) -> 2-bit index plus a valid flag (exactly one zero)
  - function encode(col,row) -> 4-bit code
- One sub-module: keypad_row_sync (2-flop synchroniser, 4 bits wide, async active-low reset to 1111).

Test Plan (SCAN_DIV=4, DEBOUNCE_CYC=8):
- Reset, no keys -> shift_col cycles 1110,1101,1011,0111 every 4 clk; key_valid=0; key_held=0.
- Hold row=1101 only while shift_col==1011 (hold afterwards), key_ready=1 -> key_valid pulses once with key_code=4'h9; key_held rises; shift_col stays 1011 until row returns to 1111 for 8 cycles.
- Same press with key_ready=0 for 50 cycles, key released at cycle 20 -> key_valid high with key_code=9 throughout; transfer on first ready edge; then release debounce; scanning resumes.
- Bounce: row toggles 1110/1111 every 3 cycles on column 0111 for 30 cycles, then stable 1110 -> no event during bounce; exactly one event with key_code=4'hC after 8 stable cycles.
- Two keys in one column (row=1100) -> no event; column keeps rotating.
- Assert reset=0 while in PRESSED with key_valid=1 -> immediately key_valid=0, key_held=0, shift_col=1110, key_code=0; scanning restarts after reset release.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state type, idle patterns and index/encoding helpers
// for the 4x4 keypad scanner.
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_e;
  localparam logic [3:0] COL_INIT = 4'b1110;
  localparam logic [3:0] ROW_IDLE = 4'b1111;
  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } onehot_idx_t;
  function automatic onehot_idx_t onehot_low_idx(input logic [3:0] v);
    onehot_idx_t r;
    r.valid = 1'b1;
    case (v)
      4'b1110: r.idx = 2'd0;
      4'b1101: r.idx = 2'd1;
      4'b1011: r.idx = 2'd2;
      4'b0111: r.idx = 2'd3;
      default: begin
        r.idx   = 2'd0;
        r.valid = 1'b0;
      end
    endcase
    return r;
  endfunction
  // True when exactly one line is pulled low (one key, no ghosting).
  function automatic logic is_single_low(input logic [3:0] v);
    logic [3:0] z;
    z = ~v;
    return (z != 4'd0) && ((z & (z - 4'd1)) == 4'd0);
  endfunction
  function automatic logic [3:0] encode(input logic [3:0] col, input logic [3:0] row);
    onehot_idx_t c;
    onehot_idx_t r;
    c = onehot_low_idx(col);
    r = onehot_low_idx(row);
    return (c.valid && r.valid) ? {c.idx, r.idx} : 4'd0;
  endfunction
endpackage

// File: rtl/keypad_row_sync.sv
// keypad_row_sync: two-flop synchroniser for the asynchronous row lines,
// reset to the idle (all released) pattern.
module keypad_row_sync
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] row_s
);
  logic [3:0] meta_q;
  logic [3:0] sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= ROW_IDLE;
      sync_q <= ROW_IDLE;
    end else begin
      meta_q <= row;
      sync_q <= meta_q;
    end
  end
  assign row_s = sync_q;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: rotates the column drive, debounces press and release, and
// hands one key code per physical press to the consumer over valid/ready.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] shift_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYC);

  logic [3:0]    row_s;
  state_e        state_q, state_d;
  logic [3:0]    col_q, col_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [3:0]    row_cap_q, row_cap_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;
  logic [3:0]    col_rot;
  logic [DW-1:0] deb_inc;
  logic          scan_last, deb_done, row_idle;

  keypad_row_sync u_sync (
    .clk   (clk),
    .rst_n (reset),
    .row   (row),
    .row_s (row_s)
  );

  assign col_rot   = {col_q[2:0], col_q[3]};
  assign deb_inc   = deb_cnt_q + DW'(1);
  assign deb_done  = deb_inc == DEB_MAX;
  assign scan_last = scan_cnt_q == SCAN_LAST;
  assign row_idle  = row_s == ROW_IDLE;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    row_cap_d  = row_cap_q;
    code_d     = code_q;
    valid_d    = valid_q;
    held_d     = held_q;
    case (state_q)
      SCAN: begin
        scan_cnt_d = scan_last ? '0 : scan_cnt_q + SW'(1);
        if (scan_last && is_single_low(row_s)) begin
          state_d   = DEBOUNCE;
          row_cap_d = row_s;
        end else if (scan_last) begin
          col_d = col_rot;
        end
      end
      DEBOUNCE: begin
        deb_cnt_d = deb_inc;
        if (row_s != row_cap_q) begin
          state_d = SCAN;
          col_d   = col_rot;
        end else if (deb_done) begin
          state_d = PRESSED;
          code_d  = encode(col_q, row_cap_q);
          valid_d = 1'b1;
          held_d  = 1'b1;
        end
      end
      PRESSED: begin
        if (valid_q && key_ready) begin
          valid_d = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        deb_cnt_d = row_idle ? deb_inc : '0;
        if (row_idle && deb_done) begin
          held_d  = 1'b0;
          col_d   = col_rot;
          state_d = SCAN;
        end
      end
      default: state_d = SCAN;
    endcase
    // Every state starts its timing from zero.
    if (state_d != state_q) begin
      scan_cnt_d = '0;
      deb_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= SCAN;
      col_q      <= COL_INIT;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      row_cap_q  <= ROW_IDLE;
      code_q     <= 4'd0;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      scan_cnt_q <= scan_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      row_cap_q  <= row_cap_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      held_q     <= held_d;
    end
  end

  assign shift_col = col_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed scenarios for the keypad scanner with a
// behavioural 4x4 switch matrix (SCAN_DIV=4, DEBOUNCE_CYC=8).
module tb_keypad_scanner;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  row;
  logic [3:0]  shift_col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic        key_held;
  logic [15:0] keys;
  int          tests = 0;
  int          fails = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYC(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .shift_col (shift_col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Key index = col*4 + row; a pressed key pulls its row low while its column is driven.
  always_comb begin
    row = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4+r] && !shift_col[c]) row[r] = 1'b0;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      ok = key_valid;
    end
  endtask

  task automatic test_reset;
    logic [3:0] exp_col [4];
    int bad;
    exp_col = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    reset = 1'b0; keys = '0; key_ready = 1'b0;
    cyc(3);
    tests++; if (shift_col !== 4'b1110) begin fails++; $display("FAIL reset_col got=%b exp=1110", shift_col); end
    tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
    tests++; if (key_held !== 1'b0) begin fails++; $display("FAIL reset_held got=%b exp=0", key_held); end
    tests++; if (key_code !== 4'h0) begin fails++; $display("FAIL reset_code got=%h exp=0", key_code); end
    reset = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tests++;
      if (shift_col !== exp_col[(k/4)%4]) begin
        fails++; $display("FAIL idle_rotate k=%0d got=%b exp=%b", k, shift_col, exp_col[(k/4)%4]);
      end
      if (key_valid !== 1'b0 || key_held !== 1'b0) bad++;
      cyc(1);
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL idle_quiet got=%0d active cycles exp=0", bad); end
  endtask

  task automatic test_press_ready;
    bit ok;
    int bad;
    key_ready = 1'b1; keys = '0; keys[9] = 1'b1;
    wait_valid(60, ok);
    tests++; if (!ok) begin fails++; $display("FAIL press_ready_timeout got=no valid exp=valid"); end
    tests++; if (key_code !== 4'h9) begin fails++; $display("FAIL press_ready_code got=%h exp=9", key_code); end
    tests++; if (key_held !== 1'b1) begin fails++; $display("FAIL press_ready_held got=%b exp=1", key_held); end
    tests++; if (shift_col !== 4'b1011) begin fails++; $display("FAIL press_ready_col got=%b exp=1011", shift_col); end
    cyc(1);
    tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL press_ready_pulse got=%b exp=0", key_valid); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (key_valid !== 1'b0 || key_held !== 1'b1 || shift_col !== 4'b1011) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL press_hold_norepeat got=%0d bad cycles exp=0", bad); end
    keys[9] = 1'b0;
    cyc(9);
    tests++; if (key_held !== 1'b1 || shift_col !== 4'b1011) begin
      fails++; $display("FAIL release_early got=held %b col %b exp=held 1 col 1011", key_held, shift_col);
    end
    cyc(1);
    tests++; if (key_held !== 1'b0 || shift_col !== 4'b0111) begin
      fails++; $display("FAIL release_done got=held %b col %b exp=held 0 col 0111", key_held, shift_col);
    end
  endtask

  task automatic test_press_wait;
    bit ok;
    int bad;
    key_ready = 1'b0; keys = '0; keys[9] = 1'b1;
    wait_valid(60, ok);
    tests++; if (!ok) begin fails++; $display("FAIL wait_timeout got=no valid exp=valid"); end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 20) keys[9] = 1'b0;
      cyc(1);
      if (key_valid !== 1'b1 || key_code !== 4'h9 || key_held !== 1'b1) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL wait_latched got=%0d bad cycles exp=0", bad); end
    key_ready = 1'b1;
    cyc(1);
    tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL wait_transfer got=%b exp=0", key_valid); end
    cyc(7);
    tests++; if (key_held !== 1'b1 || shift_col !== 4'b1011) begin
      fails++; $display("FAIL wait_release_early got=held %b col %b exp=held 1 col 1011", key_held, shift_col);
    end
    cyc(1);
    tests++; if (key_held !== 1'b0 || shift_col !== 4'b0111) begin
      fails++; $display("FAIL wait_release_done got=held %b col %b exp=held 0 col 0111", key_held, shift_col);
    end
    cyc(4);
    tests++; if (shift_col !== 4'b1110) begin fails++; $display("FAIL wait_rescan got=%b exp=1110", shift_col); end
  endtask

  task automatic test_bounce;
    bit ok;
    int vcount;
    key_ready = 1'b1; keys = '0;
    vcount = 0;
    for (int i = 0; i < 30; i++) begin
      keys[12] = ((i / 3) % 2) == 0;
      cyc(1);
      if (key_valid) vcount++;
    end
    tests++; if (vcount != 0) begin fails++; $display("FAIL bounce_quiet got=%0d valid cycles exp=0", vcount); end
    keys[12] = 1'b1;
    wait_valid(60, ok);
    tests++; if (!ok) begin fails++; $display("FAIL bounce_timeout got=no valid exp=valid"); end
    tests++; if (key_code !== 4'hC) begin fails++; $display("FAIL bounce_code got=%h exp=c", key_code); end
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (key_valid) vcount++;
    end
    tests++; if (vcount != 0) begin fails++; $display("FAIL bounce_single got=%0d extra valid cycles exp=0", vcount); end
    tests++; if (key_held !== 1'b1) begin fails++; $display("FAIL bounce_held got=%b exp=1", key_held); end
    keys[12] = 1'b0;
    cyc(12);
    tests++; if (key_held !== 1'b0) begin fails++; $display("FAIL bounce_release got=%b exp=0", key_held); end
  endtask

  task automatic test_multi_key;
    int vcount;
    logic [3:0] seen;
    key_ready = 1'b1; keys = '0; keys[0] = 1'b1; keys[1] = 1'b1;
    vcount = 0; seen = '0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      seen |= ~shift_col;
      if (key_valid || key_held) vcount++;
    end
    tests++; if (vcount != 0) begin fails++; $display("FAIL multi_noevent got=%0d active cycles exp=0", vcount); end
    tests++; if (seen !== 4'hF) begin fails++; $display("FAIL multi_rotate got=%b exp=1111", seen); end
    keys = '0;
  endtask

  task automatic test_reset_mid;
    bit ok;
    int vcount;
    key_ready = 1'b0; keys = '0; keys[9] = 1'b1;
    wait_valid(60, ok);
    tests++; if (!ok) begin fails++; $display("FAIL midrst_timeout got=no valid exp=valid"); end
    reset = 1'b0;
    #1;
    tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid got=%b exp=0", key_valid); end
    tests++; if (key_held !== 1'b0) begin fails++; $display("FAIL midrst_held got=%b exp=0", key_held); end
    tests++; if (shift_col !== 4'b1110) begin fails++; $display("FAIL midrst_col got=%b exp=1110", shift_col); end
    tests++; if (key_code !== 4'h0) begin fails++; $display("FAIL midrst_code got=%h exp=0", key_code); end
    keys = '0;
    cyc(2);
    reset = 1'b1;
    vcount = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      if (key_valid) vcount++;
    end
    tests++; if (shift_col !== 4'b1101) begin fails++; $display("FAIL midrst_rescan got=%b exp=1101", shift_col); end
    tests++; if (vcount != 0) begin fails++; $display("FAIL midrst_quiet got=%0d valid cycles exp=0", vcount); end
  endtask

  initial begin
    reset = 1'b0; keys = '0; key_ready = 1'b0;
    test_reset;
    test_press_ready;
    test_press_wait;
    test_bounce;
    test_multi_key;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
